four_bit_computer: RTL and testbench
====================================

FOUR_BIT_COMPUTER -- requirements
Module: four_bit_computer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-002 CLK  input  1  system clock; all CPU state updates on the rising edge.
REQ-003 ResetPC  input  1  synchronous active-high reset.
REQ-004 StopPC  input  1  1 = CPU frozen; program loading is allowed.
REQ-005 PRAMAddress  input  4  program-memory write address.
REQ-006 PRAMData  input  8  program-memory write data, as {opcode[7:4], operand[3:0]}.
REQ-007 PRAMWrite  input  1  program-memory write strobe.
REQ-008 Input  input  4  external data input port.
REQ-009 Output  output  4  registered output port.

Function
REQ-010 State: PC (4 bits); ACC (4 bits); C (carry flag); Z (zero flag); OUT register driving Output; data RAM of 16x4 bits; program RAM of 16x8 bits.
REQ-011 Program RAM is written on each rising edge of PRAMWrite: PRAM[PRAMAddress] <= PRAMData.
- This write is independent of CLK, StopPC and ResetPC.
- It supports 1-time-unit strobe pulses.
REQ-012 Single-cycle execution: on each CLK rising edge with ResetPC=0 and StopPC=0, the CPU executes PRAM[PC].
- The instruction's effects are visible after that edge.
- PC <= PC+1, wrapping 15->0, unless a branch is taken.
REQ-013 StopPC=1 with ResetPC=0: PC, ACC, C, Z, OUT and data RAM all hold their values.
REQ-014 Opcode map (operand a = instruction[3:0]):
- 0000 NOP.
- 0001 ADD: {C,ACC} <= ACC + DRAM[a].
- 0010 SUB: ACC <= ACC - DRAM[a]; C <= 1 if no borrow.
- 0011 STO: DRAM[a] <= ACC.
- 0100 LDA: ACC <= DRAM[a].
- 0101 B: PC <= a.
- 0110 BZ: PC <= a if Z=1.
- 0111 BC: PC <= a if C=1.
- 1000 INP: ACC <= Input.
- 1001 OUT: OUT <= ACC.
- 1010 LDI: ACC <= a.
- 1011 AND: ACC <= ACC & DRAM[a].
- 1100 OR: ACC <= ACC | DRAM[a].
- 1101 XOR: ACC <= ACC ^ DRAM[a].
- 1110 NOP.
- 1111 HLT: PC holds; only reset leaves the halt.
REQ-015 Arithmetic is 4-bit modular.
- The carry-out of ADD and SUB goes to C.
- C changes only on ADD and SUB.
REQ-016 Z <= (new ACC == 0) after every instruction that writes ACC.
- Z is unchanged by all other instructions.
REQ-017 Input is sampled at the executing CLK edge.
- Output changes only on OUT or on reset.
REQ-018 STO followed by a read of the same address in the next instruction returns the stored value.
REQ-019 Branch to the current PC address is legal and loops in place.

Reset
REQ-020 ResetPC=1 at a CLK rising edge sets PC=0, ACC=0, C=0, Z=0, OUT=0 (Output=0) and clears all 16 data-RAM words to 0.
REQ-021 Reset overrides StopPC and any instruction executing on that edge.
REQ-022 Reset does not alter program RAM.
REQ-023 Reset applied mid-program takes effect on that edge; execution resumes from PC=0 on the next edge with ResetPC=0 and StopPC=0.

Verification
REQ-024 Load INP/STO 1/INP/ADD 1/OUT/B 0 (0x80,0x31,0x80,0x11,0x90,0x50) with StopPC=1, then reset and run with Input=6.
- Required: Output=12 after 5 cycles.
- Required: Output is 0 before that point.
REQ-025 Same program with Input changed to 2 while running -> Output=4 within one loop (6 cycles).
REQ-026 Wrap/carry: LDI 9, STO 0, LDI 8, ADD 0, OUT, BC 7 (stalls at 7 via B 7) -> Output=1, C=1, and the branch is taken.
REQ-027 StopPC=1 asserted mid-loop for 10 cycles -> PC, ACC and Output frozen; the loop resumes exactly where it stopped after StopPC=0.
REQ-028 Asserting ResetPC while running -> next-cycle Output=0, PC=0, and program RAM still intact (the program reruns correctly).
REQ-029 Program writes with PRAMWrite pulses of 1 time unit, not aligned to CLK, are all stored correctly.

Source files
------------

// File: rtl/four_bit_computer.sv
// four_bit_computer: single-cycle 4-bit accumulator CPU with 16x8 program RAM and 16x4 data RAM
// Ports:
//   CLK          system clock, all CPU state updates on the rising edge
//   ResetPC      synchronous active-high reset (clears PC, ACC, C, Z, OUT, data RAM)
//   StopPC       1 = CPU frozen, program loading still allowed
//   PRAMAddress  program RAM write address
//   PRAMData     program RAM write data {opcode, operand}
//   PRAMWrite    program RAM write strobe, rising-edge triggered, independent of CLK
//   Input        external data input, sampled by INP
//   Output       registered output, updated by OUT or cleared by reset
module four_bit_computer (
    input  logic       CLK,
    input  logic       ResetPC,
    input  logic       StopPC,
    input  logic [3:0] PRAMAddress,
    input  logic [7:0] PRAMData,
    input  logic       PRAMWrite,
    input  logic [3:0] Input,
    output logic [3:0] Output
);
    logic [7:0] pram [16];
    logic [3:0] dram [16];
    logic [3:0] pc, acc, op, a, d, acc_n, pc_n;
    logic [4:0] sum, diff;
    logic       c, z, acc_w, take;
    // The strobe itself clocks the program RAM so loading works with the CPU stopped or in reset.
    always_ff @(posedge PRAMWrite)
        pram[PRAMAddress] <= PRAMData;
    always_comb begin
        op    = pram[pc][7:4];
        a     = pram[pc][3:0];
        d     = dram[a];
        sum   = {1'b0, acc} + {1'b0, d};
        diff  = {1'b0, acc} - {1'b0, d};
        acc_n = op == 4'h1 ? sum[3:0] :
                op == 4'h2 ? diff[3:0] :
                op == 4'h4 ? d :
                op == 4'h8 ? Input :
                op == 4'hA ? a :
                op == 4'hB ? acc & d :
                op == 4'hC ? acc | d :
                op == 4'hD ? acc ^ d : acc;
        acc_w = op inside {4'h1, 4'h2, 4'h4, 4'h8, 4'hA, 4'hB, 4'hC, 4'hD};
        take  = op == 4'h5 || (op == 4'h6 && z) || (op == 4'h7 && c);
        pc_n  = op == 4'hF ? pc : take ? a : pc + 4'd1;
    end
    always_ff @(posedge CLK) begin
        if (ResetPC) begin
            pc     <= '0;
            acc    <= '0;
            c      <= 1'b0;
            z      <= 1'b0;
            Output <= '0;
            for (int i = 0; i < 16; i++) dram[i] <= '0;
        end else if (!StopPC) begin
            pc <= pc_n;
            if (acc_w) begin
                acc <= acc_n;
                z   <= acc_n == 4'd0;
            end
            // SUB reports carry as "no borrow", i.e. the inverted borrow bit.
            if (op == 4'h1) c <= sum[4];
            else if (op == 4'h2) c <= ~diff[4];
            if (op == 4'h3) dram[a] <= acc;
            if (op == 4'h9) Output <= acc;
        end
    end
endmodule

// File: tb/tb_four_bit_computer.sv
// tb_four_bit_computer: directed scoreboard bench for four_bit_computer
module tb_four_bit_computer;
    logic       CLK = 1'b0;
    logic       ResetPC = 1'b0;
    logic       StopPC = 1'b1;
    logic [3:0] PRAMAddress = '0;
    logic [7:0] PRAMData = '0;
    logic       PRAMWrite = 1'b0;
    logic [3:0] Input = '0;
    logic [3:0] Output;
    typedef struct {
        string      tag;
        int         sel;
        logic [3:0] v;
    } exp_t;
    exp_t q[$];
    int passed = 0;
    int total = 0;
    four_bit_computer dut (
        .CLK(CLK), .ResetPC(ResetPC), .StopPC(StopPC), .PRAMAddress(PRAMAddress),
        .PRAMData(PRAMData), .PRAMWrite(PRAMWrite), .Input(Input), .Output(Output)
    );
    always #5 CLK = ~CLK;
    function automatic logic [3:0] obs(input int s);
        return s == 0 ? Output : s == 1 ? dut.pc : s == 2 ? dut.acc :
               s == 3 ? {3'b0, dut.c} : {3'b0, dut.z};
    endfunction
    task automatic expect_v(input string t, input int s, input logic [3:0] v);
        exp_t e;
        e.tag = t;
        e.sel = s;
        e.v = v;
        q.push_back(e);
    endtask
    task automatic chk();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            total++;
            assert (obs(e.sel) === e.v) passed++;
            else $error("FAIL %s: got %h want %h", e.tag, obs(e.sel), e.v);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask
    task automatic load(input logic [3:0] ad, input logic [7:0] da);
        PRAMAddress = ad;
        PRAMData = da;
        #1 PRAMWrite = 1'b1;
        #1 PRAMWrite = 1'b0;
        #1;
    endtask
    initial begin
        ResetPC = 1'b1;
        step(1);
        ResetPC = 1'b0;
        #3;
        // program 1: INP / STO 1 / INP / ADD 1 / OUT / B 0, loaded with off-grid 1-unit strobes
        load(0, 8'h80); load(1, 8'h31); load(2, 8'h80); load(3, 8'h11); load(4, 8'h90); load(5, 8'h50);
        step(1);
        ResetPC = 1'b1;
        expect_v("rst_out", 0, 0); expect_v("rst_pc", 1, 0); expect_v("rst_acc", 2, 0);
        expect_v("rst_c", 3, 0); expect_v("rst_z", 4, 0);
        step(1);
        chk();
        ResetPC = 1'b0;
        StopPC = 1'b0;
        Input = 4'd6;
        for (int i = 1; i <= 4; i++) begin
            expect_v($sformatf("pre_out_%0d", i), 0, 0);
            step(1);
            chk();
        end
        expect_v("sum12", 0, 12); expect_v("pc5", 1, 5);
        step(1);
        chk();
        expect_v("loop_pc0", 1, 0);
        step(1);
        chk();
        Input = 4'd2;
        expect_v("hold12", 0, 12);
        step(4);
        chk();
        expect_v("sum4", 0, 4);
        step(1);
        chk();
        Input = 4'd3;
        step(2);
        expect_v("pre_stop_pc", 1, 1); expect_v("pre_stop_acc", 2, 3);
        chk();
        StopPC = 1'b1;
        Input = 4'd7;
        expect_v("stop_pc", 1, 1); expect_v("stop_acc", 2, 3); expect_v("stop_out", 0, 4);
        step(10);
        chk();
        StopPC = 1'b0;
        Input = 4'd3;
        expect_v("resume_hold", 0, 4);
        step(3);
        chk();
        expect_v("resume_out6", 0, 6); expect_v("resume_pc5", 1, 5);
        step(1);
        chk();
        ResetPC = 1'b1;
        expect_v("midrst_out", 0, 0); expect_v("midrst_pc", 1, 0); expect_v("midrst_acc", 2, 0);
        step(1);
        chk();
        ResetPC = 1'b0;
        Input = 4'd5;
        expect_v("rerun_hold", 0, 0);
        step(4);
        chk();
        expect_v("rerun_out10", 0, 10);
        step(1);
        chk();
        // program 2: LDI 9 / STO 0 / LDI 8 / ADD 0 / OUT / BC 7 / HLT / B 7
        StopPC = 1'b1;
        #2;
        load(0, 8'hA9); load(1, 8'h30); load(2, 8'hA8); load(3, 8'h10);
        load(4, 8'h90); load(5, 8'h77); load(6, 8'hF0); load(7, 8'h57);
        step(1);
        ResetPC = 1'b1;
        step(1);
        ResetPC = 1'b0;
        StopPC = 1'b0;
        expect_v("wrap_out1", 0, 1); expect_v("wrap_c1", 3, 1); expect_v("wrap_z0", 4, 0);
        step(5);
        chk();
        expect_v("bc_taken", 1, 7);
        step(1);
        chk();
        expect_v("b_self_pc", 1, 7); expect_v("b_self_out", 0, 1);
        step(10);
        chk();
        // program 3: SUB/borrow, AND, XOR->Z, BZ, OR, BC not taken, HLT
        StopPC = 1'b1;
        load(0, 8'hA5); load(1, 8'h30); load(2, 8'hA3); load(3, 8'h31);
        load(4, 8'h40); load(5, 8'h21); load(6, 8'h21); load(7, 8'hB0);
        load(8, 8'hD0); load(9, 8'h6C); load(10, 8'h90); load(11, 8'hF0);
        load(12, 8'hC1); load(13, 8'h90); load(14, 8'h7F); load(15, 8'hFF);
        step(1);
        ResetPC = 1'b1;
        step(1);
        ResetPC = 1'b0;
        StopPC = 1'b0;
        expect_v("sub_acc2", 2, 2); expect_v("sub_nob_c1", 3, 1); expect_v("sub_z0", 4, 0);
        step(6);
        chk();
        expect_v("sub_wrap_f", 2, 4'hF); expect_v("sub_borrow_c0", 3, 0);
        step(1);
        chk();
        expect_v("and_5", 2, 5);
        step(1);
        chk();
        expect_v("xor_0", 2, 0); expect_v("xor_z1", 4, 1);
        step(1);
        chk();
        expect_v("bz_taken", 1, 12);
        step(1);
        chk();
        expect_v("or_3", 2, 3); expect_v("or_z0", 4, 0);
        step(1);
        chk();
        expect_v("out3", 0, 3);
        step(1);
        chk();
        expect_v("bc_not_taken", 1, 15);
        step(1);
        chk();
        expect_v("hlt_pc", 1, 15); expect_v("hlt_out", 0, 3);
        step(5);
        chk();
        StopPC = 1'b1;
        ResetPC = 1'b1;
        expect_v("rst_over_stop_out", 0, 0); expect_v("rst_over_stop_pc", 1, 0);
        step(1);
        chk();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
